// File: rtl/baby_store_arbiter.sv
// Manchester Baby 32x32 store shared by the CPU port and a host load/debug port, plus core life-cycle FSM.
// Optional: define BABY_STORE_WRITE_PROTECT_EN to refuse host writes while the core is running.
`timescale 1ns/1ps
module baby_store_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_i,
    input  logic              cpu_strobe_i,
    input  logic              cpu_rw_en_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_reset_o,
    input  logic              stop_lamp_i,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_ack_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_err_o,
    input  logic              host_run_i,
    output logic [1:0]        state_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'b00,
        ST_RUN     = 2'b01,
        ST_STOPPED = 2'b10
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              stop_lamp_q;
    logic              host_pending_q;
    logic              cpu_access;
    logic              host_grant;
    logic              host_refused;
    logic              host_mem_we;
    logic              stop_edge;

    // Strobes only reach the store while running; otherwise the host owns every cycle.
    assign cpu_access  = (state_q == ST_RUN) && cpu_strobe_i;
    assign host_grant  = host_pending_q && !cpu_access;
    assign stop_edge   = stop_lamp_i && !stop_lamp_q;
    assign host_mem_we = host_grant && host_we_i && !host_refused;
    assign cpu_reset_o = (state_q == ST_LOAD);
    assign state_o     = state_q;

`ifdef BABY_STORE_WRITE_PROTECT_EN
    logic host_err_q;

    assign host_refused = host_we_i && (state_q == ST_RUN);
    assign host_err_o   = host_err_q;

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            host_err_q <= 1'b0;
        end else begin
            host_err_q <= host_grant && host_refused;
        end
    end
`else
    assign host_refused = 1'b0;
    assign host_err_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:    if (host_run_i) state_d = ST_RUN;
            ST_RUN:     if (stop_edge)  state_d = ST_STOPPED;
            ST_STOPPED: if (host_run_i) state_d = ST_LOAD;
            default:    state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_LOAD;
            stop_lamp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_lamp_q <= stop_lamp_i;
        end
    end

    // CPU and host never share a cycle, so at most one write port is live.
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (cpu_access && cpu_rw_en_i) begin
            mem[cpu_addr_i] <= cpu_wdata_i;
        end else if (host_mem_we) begin
            mem[host_addr_i] <= host_wdata_i;
        end
    end

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            cpu_rdata_o <= '0;
        end else if (cpu_access && !cpu_rw_en_i) begin
            cpu_rdata_o <= mem[cpu_addr_i];
        end
    end

    // A request is registered first; a request still high during its ack counts as a new one.
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            host_pending_q <= 1'b0;
            host_ack_o     <= 1'b0;
            host_rdata_o   <= '0;
        end else begin
            host_ack_o     <= host_grant;
            host_pending_q <= host_grant ? 1'b0 : (host_pending_q | host_req_i);
            if (host_grant) begin
                host_rdata_o <= mem[host_addr_i];
            end
        end
    end

endmodule

// File: tb/tb_baby_store_arbiter.sv
// Self-checking bench for baby_store_arbiter: directed life-cycle sequence plus randomized
// CPU/host/control traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_baby_store_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
`ifdef BABY_STORE_WRITE_PROTECT_EN
    localparam bit WRITE_PROTECT = 1'b1;
`else
    localparam bit WRITE_PROTECT = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_i = 1'b0;
    logic              cpu_strobe_i = 1'b0;
    logic              cpu_rw_en_i = 1'b0;
    logic [ADDR_W-1:0] cpu_addr_i = '0;
    logic [DATA_W-1:0] cpu_wdata_i = '0;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_reset_o;
    logic              stop_lamp_i = 1'b0;
    logic              host_req_i = 1'b0;
    logic              host_we_i = 1'b0;
    logic [ADDR_W-1:0] host_addr_i = '0;
    logic [DATA_W-1:0] host_wdata_i = '0;
    logic              host_ack_o;
    logic [DATA_W-1:0] host_rdata_o;
    logic              host_err_o;
    logic              host_run_i = 1'b0;
    logic [1:0]        state_o;

    int checks = 0;
    int failures = 0;

    baby_store_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock        (clock),
        .reset_i      (reset_i),
        .cpu_strobe_i (cpu_strobe_i),
        .cpu_rw_en_i  (cpu_rw_en_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_reset_o  (cpu_reset_o),
        .stop_lamp_i  (stop_lamp_i),
        .host_req_i   (host_req_i),
        .host_we_i    (host_we_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_ack_o   (host_ack_o),
        .host_rdata_o (host_rdata_o),
        .host_err_o   (host_err_o),
        .host_run_i   (host_run_i),
        .state_o      (state_o)
    );

    always #5 clock = ~clock;

    // Behavioural model: mode 0 LOAD, 1 RUN, 2 STOPPED; a seen host request waits for a free slot.
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                model_mode = 0;
    bit                model_waiting = 1'b0;
    bit                model_lamp_seen = 1'b0;
    bit                model_ok = 1'b0;
    bit                cpu_busy;
    bit                served;
    bit                refused;
    logic [DATA_W-1:0] exp_cpu_rdata = '0;
    logic [DATA_W-1:0] exp_host_rdata = '0;
    bit                exp_ack = 1'b0;
    bit                exp_err = 1'b0;

    initial begin
        forever begin
            @(posedge clock or posedge reset_i);
            if (reset_i) begin
                foreach (model_mem[i]) model_mem[i] = '0;
                model_mode      = 0;
                model_waiting   = 1'b0;
                model_lamp_seen = 1'b0;
                exp_cpu_rdata   = '0;
                exp_host_rdata  = '0;
                exp_ack         = 1'b0;
                exp_err         = 1'b0;
                model_ok        = 1'b1;
            end else begin
                cpu_busy = (model_mode == 1) && cpu_strobe_i;
                served   = model_waiting && !cpu_busy;
                refused  = served && host_we_i && WRITE_PROTECT && (model_mode == 1);
                exp_ack  = served;
                exp_err  = refused;
                if (served) begin
                    exp_host_rdata = model_mem[host_addr_i];
                    if (host_we_i && !refused) model_mem[host_addr_i] = host_wdata_i;
                end
                if (cpu_busy) begin
                    if (cpu_rw_en_i) model_mem[cpu_addr_i] = cpu_wdata_i;
                    else             exp_cpu_rdata = model_mem[cpu_addr_i];
                end
                model_waiting = served ? 1'b0 : (model_waiting || host_req_i);
                case (model_mode)
                    0: if (host_run_i) model_mode = 1;
                    1: if (stop_lamp_i && !model_lamp_seen) model_mode = 2;
                    2: if (host_run_i) model_mode = 0;
                    default: model_mode = 0;
                endcase
                model_lamp_seen = stop_lamp_i;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: every cycle outside reset, half a clock after the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (model_ok && !reset_i) begin
                checkOutput("model_state_o", 32'(state_o), 32'(model_mode));
                checkOutput("model_cpu_reset_o", 32'(cpu_reset_o), 32'(model_mode == 0));
                checkOutput("model_cpu_rdata_o", cpu_rdata_o, exp_cpu_rdata);
                checkOutput("model_host_ack_o", 32'(host_ack_o), 32'(exp_ack));
                checkOutput("model_host_err_o", 32'(host_err_o), 32'(exp_err));
                if (exp_ack) checkOutput("model_host_rdata_o", host_rdata_o, exp_host_rdata);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where the ack is visible.
    task automatic hostAccess(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                              output logic [DATA_W-1:0] rdata, output bit err, output int latency);
        host_req_i   = 1'b1;
        host_we_i    = we;
        host_addr_i  = addr;
        host_wdata_i = wdata;
        latency      = 0;
        do begin
            @(negedge clock);
            latency++;
        end while (!host_ack_o && latency < 50);
        if (!host_ack_o) begin
            checks++;
            failures++;
            $display("[TB] FAIL host_ack_timeout actual=no_ack expected=ack addr=%0d", addr);
        end
        rdata      = host_rdata_o;
        err        = host_err_o;
        host_req_i = 1'b0;
    endtask

    task automatic cpuAccess(input bit rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        cpu_strobe_i = 1'b1;
        cpu_rw_en_i  = rw;
        cpu_addr_i   = addr;
        cpu_wdata_i  = wdata;
        @(negedge clock);
        cpu_strobe_i = 1'b0;
    endtask

    task automatic pulseRun();
        host_run_i = 1'b1;
        @(negedge clock);
        host_run_i = 1'b0;
    endtask

    // Randomized traffic: CPU strobes, control pulses and a protocol-obeying host all at once.
    task automatic applyStimulus(input int cycles);
        fork
            begin
                for (int c = 0; c < cycles; c++) begin
                    cpu_strobe_i = 1'($urandom_range(0, 1));
                    cpu_rw_en_i  = 1'($urandom_range(0, 1));
                    cpu_addr_i   = ADDR_W'($urandom_range(0, DEPTH - 1));
                    cpu_wdata_i  = $urandom;
                    @(negedge clock);
                end
                cpu_strobe_i = 1'b0;
            end
            begin
                for (int c = 0; c < cycles; c++) begin
                    host_run_i = ($urandom_range(0, 24) == 0);
                    if ($urandom_range(0, 15) == 0) stop_lamp_i = ~stop_lamp_i;
                    @(negedge clock);
                end
                host_run_i  = 1'b0;
                stop_lamp_i = 1'b0;
            end
            begin
                int waited;
                waited = 0;
                for (int c = 0; c < cycles; c++) begin
                    if (host_req_i) begin
                        if (host_ack_o) begin
                            if ($urandom_range(0, 3) == 0) begin
                                host_we_i    = 1'($urandom_range(0, 1));
                                host_addr_i  = ADDR_W'($urandom_range(0, DEPTH - 1));
                                host_wdata_i = $urandom;
                            end else begin
                                host_req_i = 1'b0;
                            end
                            waited = 0;
                        end else begin
                            waited++;
                            if (waited > 60) begin
                                checks++;
                                failures++;
                                $display("[TB] FAIL random_host_ack_timeout actual=no_ack expected=ack");
                                host_req_i = 1'b0;
                                waited = 0;
                            end
                        end
                    end else if ($urandom_range(0, 2) == 0) begin
                        host_req_i   = 1'b1;
                        host_we_i    = 1'($urandom_range(0, 1));
                        host_addr_i  = ADDR_W'($urandom_range(0, DEPTH - 1));
                        host_wdata_i = $urandom;
                        waited = 0;
                    end
                    @(negedge clock);
                end
                waited = 0;
                while (host_req_i && !host_ack_o && waited < 60) begin
                    @(negedge clock);
                    waited++;
                end
                host_req_i = 1'b0;
            end
        join
    endtask

    logic [DATA_W-1:0] rd;
    bit                er;
    int                lat;

    initial begin
        #2 reset_i = 1'b1;
        repeat (3) @(negedge clock);
        reset_i = 1'b0;
        checkOutput("reset_state_o", 32'(state_o), 32'd0);
        checkOutput("reset_cpu_reset_o", 32'(cpu_reset_o), 32'd1);
        checkOutput("reset_cpu_rdata_o", cpu_rdata_o, 32'd0);
        checkOutput("reset_host_rdata_o", host_rdata_o, 32'd0);
        checkOutput("reset_host_ack_o", 32'(host_ack_o), 32'd0);
        checkOutput("reset_host_err_o", 32'(host_err_o), 32'd0);

        for (int a = 0; a < DEPTH; a++) begin
            hostAccess(1'b0, ADDR_W'(a), '0, rd, er, lat);
            checkOutput("reset_word_zero", rd, 32'd0);
        end

        // LOAD: program the store, ack two cycles after the request.
        hostAccess(1'b1, 5'd1, 32'h0000401f, rd, er, lat);
        checkOutput("load_write_latency", 32'(lat), 32'd2);
        checkOutput("load_write_err", 32'(er), 32'd0);
        hostAccess(1'b0, 5'd1, '0, rd, er, lat);
        checkOutput("load_read_addr1", rd, 32'h0000401f);
        hostAccess(1'b1, 5'd0, 32'hA5A50000, rd, er, lat);

        pulseRun();
        checkOutput("run_state_o", 32'(state_o), 32'd1);
        checkOutput("run_cpu_reset_o", 32'(cpu_reset_o), 32'd0);

        cpuAccess(1'b0, 5'd1, '0);
        checkOutput("cpu_read_addr1", cpu_rdata_o, 32'h0000401f);
        cpuAccess(1'b1, 5'd31, 32'h00000024);
        hostAccess(1'b0, 5'd31, '0, rd, er, lat);
        checkOutput("host_read_cpu_write", rd, 32'h00000024);
        checkOutput("run_idle_latency", 32'(lat), 32'd2);

        // Contention: three back-to-back CPU reads starting the cycle after the request.
        host_req_i  = 1'b1;
        host_we_i   = 1'b0;
        host_addr_i = 5'd31;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (!host_ack_o) begin
                cpu_strobe_i = (lat <= 3);
                cpu_rw_en_i  = 1'b0;
                cpu_addr_i   = 5'd1;
            end
        end while (!host_ack_o && lat < 50);
        rd = host_rdata_o;
        host_req_i   = 1'b0;
        cpu_strobe_i = 1'b0;
        checkOutput("contention_latency", 32'(lat), 32'd5);
        checkOutput("contention_rdata", rd, 32'h00000024);
        checkOutput("contention_cpu_rdata", cpu_rdata_o, 32'h0000401f);

        hostAccess(1'b1, 5'd5, 32'h00000055, rd, er, lat);
        checkOutput("run_write_err", 32'(er), 32'(WRITE_PROTECT));
        hostAccess(1'b0, 5'd5, '0, rd, er, lat);
        checkOutput("run_write_result", rd, WRITE_PROTECT ? 32'd0 : 32'h00000055);

        stop_lamp_i = 1'b1;
        @(negedge clock);
        checkOutput("stopped_state_o", 32'(state_o), 32'd2);
        checkOutput("stopped_cpu_reset_o", 32'(cpu_reset_o), 32'd0);
        cpuAccess(1'b1, 5'd0, 32'hFFFFFFFF);
        hostAccess(1'b0, 5'd0, '0, rd, er, lat);
        checkOutput("stopped_store_frozen", rd, 32'hA5A50000);
        pulseRun();
        checkOutput("reload_state_o", 32'(state_o), 32'd0);
        checkOutput("reload_cpu_reset_o", 32'(cpu_reset_o), 32'd1);
        stop_lamp_i = 1'b0;
        @(negedge clock);

        applyStimulus(3000);
        repeat (2) @(negedge clock);

        // Reset during the grant cycle: no ack, store cleared.
        host_req_i   = 1'b1;
        host_we_i    = 1'b1;
        host_addr_i  = 5'd7;
        host_wdata_i = 32'hDEADBEEF;
        @(posedge clock);
        #2 reset_i = 1'b1;
        @(negedge clock);
        host_req_i = 1'b0;
        @(negedge clock);
        reset_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOutput("abort_no_ack", 32'(host_ack_o), 32'd0);
        end
        hostAccess(1'b0, 5'd7, '0, rd, er, lat);
        checkOutput("abort_store_cleared", rd, 32'd0);
        checkOutput("abort_state_o", 32'(state_o), 32'd0);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
